xc_malu_mul_iter: RTL and testbench
===================================

Name: xc_malu_mul_iter

Overview:
- Iterative radix-2 shift-and-add multiplier for mul, mulh, mulhu and mulhsu; the multiply counterpart to the MALU divide/remainder unit.
- Sits inside the MALU and shares the MALU packed adder through the padd_* port group. It drives the adder inputs and consumes the result and carry.
- Holds its own 64-bit accumulator, multiplier register and iteration counter.
- Produces the low or high 32-bit word of the 64-bit product.

Parameters:
- none

Ports:
- clock  input  1  — single clock; all state updates on the rising edge.
- resetn  input  1  — synchronous, active-low reset.
- rs1  input  32  — multiplicand operand.
- rs2  input  32  — multiplier operand.
- valid  input  1  — operation request; held high until flush.
- lhs_signed  input  1  — treat rs1 as two's complement.
- rhs_signed  input  1  — treat rs2 as two's complement.
- op_hi  input  1  — 1 returns product[63:32]; 0 returns product[31:0].
- op_clmul  input  1  — carry-less multiply; used only with the optional feature.
- flush  input  1  — abort and return to IDLE.
- padd_lhs  output  32  — adder left input.
- padd_rhs  output  32  — adder right input.
- padd_sub  output  1  — adder subtract select; tied 0.
- padd_cout  input  32  — adder per-bit carries; bit 31 is carry out.
- padd_result  input  32  — adder sum.
- result  output  32  — selected product word; valid while ready=1.
- ready  output  1  — result valid.

Behaviour:
- State machine: IDLE, RUN, DONE.
- Registers:
  - acc[63:0]
  - mcand[31:0]
  - mplier[31:0]
  - cnt[5:0]
  - neg (1 bit)
- Reset (resetn=0 at a clock edge):
  - state=IDLE; acc, mcand, mplier and cnt = 0; neg=0.
  - ready=0, result=0.
- Flush:
  - flush=1 has the same effect as reset on state, cnt and ready.
  - Flush outranks valid. valid and flush high together means no start.
- IDLE:
  - valid=1 loads on that edge: mcand=|rs1| if lhs_signed&rs1[31], else rs1; mplier=|rs2| likewise using rhs_signed and rs2[31].
  - neg=(lhs_signed&rs1[31])^(rhs_signed&rs2[31]); acc=0; cnt=0; state→RUN.
  - |0x80000000| is 0x80000000, interpreted unsigned.
- RUN, per cycle:
  - padd_lhs=acc[63:32]; padd_rhs=mplier[0]?mcand:0.
  - acc ← {padd_cout[31], padd_result, acc[31:1]}; mplier ← mplier>>1; cnt ← cnt+1.
  - When cnt==31 the update is applied and state→DONE.
  - Exactly 32 RUN cycles.
- DONE:
  - ready=1; acc frozen.
  - Holds until flush or reset. valid is ignored while in DONE.
- Output selection: p = neg ? (~acc+1) : acc (64-bit). result = op_hi ? p[63:32] : p[31:0].
- result is 0 whenever state≠DONE.
- Adder ports outside RUN: padd_lhs=0, padd_rhs=0. padd_sub is always 0.
- Latency: valid sampled at edge E0; ready=1 after edge E33 (33 clocks); result is valid in the same cycle.
- Operand stability: rs1, rs2 and the sign flags are sampled only at the IDLE load. op_hi and op_clmul are read combinationally in DONE and are held stable by the MALU.
- Zero product with neg=1 yields 0.

Optional Feature:
- Macro: XC_MALU_MUL_CLMUL_EN.
- Defined:
  - op_clmul is latched at the IDLE load.
  - When the latched op_clmul=1: each RUN step uses sum=acc[63:32]^(mplier[0]?mcand:0) with carry 0, i.e. acc ← {1'b0, sum, acc[31:1]}.
  - The padd outputs are driven 0 in clmul mode. Sign handling is disabled (neg=0, operands used raw).
  - Latency and handshake are unchanged.
- Undefined: the op_clmul port remains but is ignored (treated as 0), and no XOR datapath is built.

Test Plan:
- Unsigned low word: rs1=0x0000FFFF, rs2=0x0000FFFF, op_hi=0, signed flags 0 → ready rises 33 clocks after valid, result=0xFFFE0001, padd_sub=0 throughout.
- Unsigned high/low: rs1=rs2=0xFFFFFFFF, unsigned, op_hi=1 → 0xFFFFFFFE; re-read with op_hi=0 in DONE → 0x00000001.
- Signed: mulh 0x80000000×0x80000000 → 0x40000000; mulh 0xFFFFFFFF×0xFFFFFFFF → 0x00000000; mulhsu rs1=0xFFFFFFFF (signed) × rs2=0xFFFFFFFF (unsigned) → 0xFFFFFFFF, low word 0x00000001.
- Flush and restart: flush on 10th RUN cycle → next cycle ready=0, state IDLE; new request 7×6 unsigned low → result=0x0000002A after 33 clocks. valid and flush asserted together in IDLE → no start.
- Reset mid-run: resetn=0 for one edge during RUN → ready=0, result=0, padd_lhs=padd_rhs=0. A subsequent operation completes correctly. ready stays high across 5 idle cycles in DONE until flush.
- With XC_MALU_MUL_CLMUL_EN: op_clmul=1, 0x3×0x3 → low word 0x00000005 (0x00000009 with op_clmul=0). Without the macro, op_clmul=1 → 0x00000009.

Source files
------------

// File: rtl/xc_malu_mul_iter_if.sv
// Request/response handshake and shared packed-adder port group between the MALU and
// its iterative multiplier. The master side is the MALU, the slave side the multiplier.
interface xc_malu_mul_iter_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            valid;
  logic            lhs_signed;
  logic            rhs_signed;
  logic            op_hi;
  logic            op_clmul;
  logic            flush;

  logic [XLEN-1:0] padd_lhs;
  logic [XLEN-1:0] padd_rhs;
  logic            padd_sub;
  logic [XLEN-1:0] padd_cout;
  logic [XLEN-1:0] padd_result;

  logic [XLEN-1:0] result;
  logic            ready;

  modport master (
    output rs1, rs2, valid, lhs_signed, rhs_signed, op_hi, op_clmul, flush,
    output padd_cout, padd_result,
    input  padd_lhs, padd_rhs, padd_sub,
    input  result, ready
  );

  modport slave (
    input  rs1, rs2, valid, lhs_signed, rhs_signed, op_hi, op_clmul, flush,
    input  padd_cout, padd_result,
    output padd_lhs, padd_rhs, padd_sub,
    output result, ready
  );
endinterface

// File: rtl/xc_malu_mul_iter.sv
// Iterative radix-2 shift-and-add multiplier (mul/mulh/mulhu/mulhsu) sharing the MALU adder.
// Optional carry-less multiply datapath is built when XC_MALU_MUL_CLMUL_EN is defined.
module xc_malu_mul_iter (
  input  logic               clock,
  input  logic               resetn,
  xc_malu_mul_iter_if.slave  bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     acc;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              ready_q;

  logic              lhs_neg_c;
  logic              rhs_neg_c;
  logic [XLEN-1:0]   lhs_mag_c;
  logic [XLEN-1:0]   rhs_mag_c;
  logic [XLEN-1:0]   addend_c;
  logic [XLEN-1:0]   step_hi_c;
  logic              step_carry_c;
  logic              adder_en_c;
  logic [PW-1:0]     prod_c;
  logic              unused_c;

  assign addend_c = mplier[0] ? mcand : '0;

`ifdef XC_MALU_MUL_CLMUL_EN
  logic clmul;

  // Carry-less mode uses raw operands and an XOR step instead of the shared adder.
  assign lhs_neg_c    = bus.lhs_signed & bus.rs1[XLEN-1] & ~bus.op_clmul;
  assign rhs_neg_c    = bus.rhs_signed & bus.rs2[XLEN-1] & ~bus.op_clmul;
  assign adder_en_c   = (state == RUN) & ~clmul;
  assign step_hi_c    = clmul ? (acc[PW-1:XLEN] ^ addend_c) : bus.padd_result;
  assign step_carry_c = ~clmul & bus.padd_cout[XLEN-1];
  assign unused_c     = ^bus.padd_cout[XLEN-2:0];
`else
  assign lhs_neg_c    = bus.lhs_signed & bus.rs1[XLEN-1];
  assign rhs_neg_c    = bus.rhs_signed & bus.rs2[XLEN-1];
  assign adder_en_c   = (state == RUN);
  assign step_hi_c    = bus.padd_result;
  assign step_carry_c = bus.padd_cout[XLEN-1];
  assign unused_c     = ^{bus.op_clmul, bus.padd_cout[XLEN-2:0]};
`endif

  // Magnitudes; |0x80000000| wraps to itself and is then treated as unsigned.
  assign lhs_mag_c = lhs_neg_c ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
  assign rhs_mag_c = rhs_neg_c ? (~bus.rs2 + XLEN'(1)) : bus.rs2;

  assign bus.padd_lhs = adder_en_c ? acc[PW-1:XLEN] : '0;
  assign bus.padd_rhs = adder_en_c ? addend_c : '0;
  assign bus.padd_sub = 1'b0;

  // op_hi is held stable by the MALU while the result is presented.
  assign prod_c     = neg ? (~acc + PW'(1)) : acc;
  assign bus.result = ready_q ? (bus.op_hi ? prod_c[PW-1:XLEN] : prod_c[XLEN-1:0]) : '0;
  assign bus.ready  = ready_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ready_q <= 1'b0;
`ifdef XC_MALU_MUL_CLMUL_EN
      clmul   <= 1'b0;
`endif
    end else if (bus.flush) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      // ready trails entry into DONE by one clock
      ready_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.valid) begin
            mcand  <= lhs_mag_c;
            mplier <= rhs_mag_c;
            neg    <= lhs_neg_c ^ rhs_neg_c;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
`ifdef XC_MALU_MUL_CLMUL_EN
            clmul  <= bus.op_clmul;
`endif
          end
        end
        RUN: begin
          acc    <= {step_carry_c, step_hi_c, acc[XLEN-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xc_malu_mul_iter.sv
// Self-checking bench for xc_malu_mul_iter: directed cases plus randomized operands
// checked against an arithmetic product model; the shared adder is modelled here.
module tb_xc_malu_mul_iter;
  logic clock;
  logic resetn;
  int   n_checks;
  int   n_fail;

  xc_malu_mul_iter_if bus ();

  xc_malu_mul_iter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Shared MALU adder: sum plus per-bit carry-out vector.
  logic [32:0] add_s;
  assign add_s           = {1'b0, bus.padd_lhs} + {1'b0, bus.padd_rhs};
  assign bus.padd_result = add_s[31:0];
  assign bus.padd_cout   = {add_s[32], add_s[31:1] ^ bus.padd_lhs[31:1] ^ bus.padd_rhs[31:1]};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb, input logic cl);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] p;
    logic        cl_eff;
`ifdef XC_MALU_MUL_CLMUL_EN
    cl_eff = cl;
`else
    cl_eff = 1'b0;
`endif
    if (cl_eff) begin
      p = 64'h0;
      for (int i = 0; i < 32; i++) begin
        if (b[i]) p = p ^ (64'(a) << i);
      end
      return p;
    end
    x = sa ? {{32{a[31]}}, a} : {32'h0, a};
    y = sb ? {{32{b[31]}}, b} : {32'h0, b};
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic hi, input logic cl);
    bus.rs1        = a;
    bus.rs2        = b;
    bus.lhs_signed = sa;
    bus.rhs_signed = sb;
    bus.op_hi      = hi;
    bus.op_clmul   = cl;
    bus.valid      = 1'b1;
  endtask

  // Returns clocks from the valid-sampling edge until ready is seen (99 on timeout).
  task automatic wait_done(output int lat, output logic sub_seen);
    int n;
    n = 0;
    sub_seen = 1'b0;
    do begin
      tick();
      n++;
      if (bus.padd_sub !== 1'b0) sub_seen = 1'b1;
    end while (bus.ready !== 1'b1 && n < 100);
    lat = n - 1;
  endtask

  task automatic do_flush();
    bus.valid = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.rs1 = '0; bus.rs2 = '0; bus.valid = 1'b0; bus.lhs_signed = 1'b0;
    bus.rhs_signed = 1'b0; bus.op_hi = 1'b0; bus.op_clmul = 1'b0; bus.flush = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", bus.ready); end
    n_checks++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %08h want 0", bus.result); end
    n_checks++;
    if (bus.padd_lhs !== 32'h0 || bus.padd_rhs !== 32'h0) begin
      n_fail++; $display("FAIL reset_padd got lhs=%08h rhs=%08h want 0/0", bus.padd_lhs, bus.padd_rhs);
    end
    resetn = 1'b1;
    tick();
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %0b want 0", bus.ready); end
  endtask

  task automatic test_unsigned_low();
    int lat;
    logic sub_seen;
    issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat, sub_seen);
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL ulow_latency got %0d want 33", lat); end
    n_checks++;
    if (bus.result !== 32'hFFFE0001) begin n_fail++; $display("FAIL ulow_result got %08h want fffe0001", bus.result); end
    n_checks++;
    if (sub_seen !== 1'b0) begin n_fail++; $display("FAIL ulow_padd_sub got 1 want 0"); end
    do_flush();
  endtask

  task automatic test_unsigned_hilo();
    int lat;
    logic sub_seen;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat, sub_seen);
    n_checks++;
    if (bus.result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL uhi_result got %08h want fffffffe", bus.result); end
    bus.op_hi = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== 32'h00000001) begin n_fail++; $display("FAIL ulo_reread got %08h want 00000001", bus.result); end
    do_flush();
  endtask

  task automatic test_signed();
    logic [31:0] ta [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFF9};
    logic [31:0] tb [5] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
    logic        tsa [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tsb [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] thi [5] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] tlo [5] = '{32'h00000000, 32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFEB};
    int lat;
    logic sub_seen;
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], tsa[i], tsb[i], 1'b1, 1'b0);
      wait_done(lat, sub_seen);
      n_checks++;
      if (bus.result !== thi[i]) begin n_fail++; $display("FAIL signed_hi[%0d] got %08h want %08h", i, bus.result, thi[i]); end
      bus.op_hi = 1'b0;
      #1;
      n_checks++;
      if (bus.result !== tlo[i]) begin n_fail++; $display("FAIL signed_lo[%0d] got %08h want %08h", i, bus.result, tlo[i]); end
      do_flush();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sa, sb, cl;
    logic [63:0] p;
    int lat;
    logic sub_seen;
    for (int i = 0; i < 30; i++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h0;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 4) == 0);
      p  = ref_product(a, b, sa, sb, cl);
      issue(a, b, sa, sb, 1'b1, cl);
      wait_done(lat, sub_seen);
      n_checks++;
      if (lat != 33 || sub_seen !== 1'b0) begin
        n_fail++; $display("FAIL rand_latency[%0d] got lat=%0d sub=%0b want 33/0", i, lat, sub_seen);
      end
      n_checks++;
      if (bus.result !== p[63:32]) begin
        n_fail++; $display("FAIL rand_hi[%0d] a=%08h b=%08h s=%0b%0b c=%0b got %08h want %08h",
                           i, a, b, sa, sb, cl, bus.result, p[63:32]);
      end
      bus.op_hi = 1'b0;
      #1;
      n_checks++;
      if (bus.result !== p[31:0]) begin
        n_fail++; $display("FAIL rand_lo[%0d] a=%08h b=%08h s=%0b%0b c=%0b got %08h want %08h",
                           i, a, b, sa, sb, cl, bus.result, p[31:0]);
      end
      do_flush();
    end
  endtask

  task automatic test_flush_restart();
    int lat;
    logic sub_seen;
    issue(32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) tick();
    n_checks++;
    if (bus.padd_rhs !== 32'h12345678) begin
      n_fail++; $display("FAIL run_padd_rhs got %08h want 12345678", bus.padd_rhs);
    end
    do_flush();
    n_checks++;
    if (bus.ready !== 1'b0 || bus.padd_lhs !== 32'h0 || bus.padd_rhs !== 32'h0) begin
      n_fail++; $display("FAIL flush_idle got ready=%0b lhs=%08h rhs=%08h want 0/0/0",
                         bus.ready, bus.padd_lhs, bus.padd_rhs);
    end
    issue(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat, sub_seen);
    n_checks++;
    if (lat != 33 || bus.result !== 32'h0000002A) begin
      n_fail++; $display("FAIL restart got lat=%0d result=%08h want 33/0000002a", lat, bus.result);
    end
    do_flush();
    // valid together with flush must not start an operation
    issue(32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.padd_rhs !== 32'h0) begin n_fail++; $display("FAIL valid_flush_start got padd_rhs=%08h want 0", bus.padd_rhs); end
    for (int i = 0; i < 40; i++) tick();
    n_checks++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL valid_flush_ready got %0b want 0", bus.ready); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    logic sub_seen;
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    bus.valid = 1'b0;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.result !== 32'h0 || bus.padd_lhs !== 32'h0 || bus.padd_rhs !== 32'h0) begin
      n_fail++; $display("FAIL midrun_reset got ready=%0b result=%08h lhs=%08h rhs=%08h want all 0",
                         bus.ready, bus.result, bus.padd_lhs, bus.padd_rhs);
    end
    issue(32'h00001234, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat, sub_seen);
    n_checks++;
    if (lat != 33 || bus.result !== 32'h00012340) begin
      n_fail++; $display("FAIL after_reset got lat=%0d result=%08h want 33/00012340", lat, bus.result);
    end
  endtask

  task automatic test_done_hold();
    logic ok;
    ok = 1'b1;
    bus.valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        bus.valid = 1'b1;
        bus.rs1   = 32'hDEADBEEF;
      end
      tick();
      if (bus.ready !== 1'b1 || bus.result !== 32'h00012340) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL done_hold got ready=%0b result=%08h want 1/00012340", bus.ready, bus.result);
    end
    do_flush();
    n_checks++;
    if (bus.ready !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++; $display("FAIL done_flush got ready=%0b result=%08h want 0/0", bus.ready, bus.result);
    end
  endtask

  task automatic test_clmul();
    int lat;
    logic sub_seen;
    logic [31:0] want;
`ifdef XC_MALU_MUL_CLMUL_EN
    want = 32'h00000005;
`else
    want = 32'h00000009;
`endif
    issue(32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(lat, sub_seen);
    n_checks++;
    if (lat != 33 || bus.result !== want) begin
      n_fail++; $display("FAIL clmul_on got lat=%0d result=%08h want 33/%08h", lat, bus.result, want);
    end
    do_flush();
    issue(32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(lat, sub_seen);
    n_checks++;
    if (bus.result !== 32'h00000009) begin n_fail++; $display("FAIL clmul_off got %08h want 00000009", bus.result); end
    do_flush();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    test_reset();
    test_unsigned_low();
    test_unsigned_hilo();
    test_signed();
    test_flush_restart();
    test_reset_midrun();
    test_done_hold();
    test_clmul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
